ms_otf_conv: RTL and testbench
==============================

// Module: ms_otf_conv
// PURPOSE
//  Downstream stage of ms_serial_by2_mul. Consumes the MSDF radix-2 signed-digit stream,
//  one digit per valid cycle, most significant first.
//  Converts the stream to a conventional two's-complement integer using on-the-fly
//  conversion (Q/QM registers), so no carry-propagate adder is needed at the end.
//  Pulses result_valid when the word is complete. Gives benches and the arch sweep a
//  binary value to compare.
// PARAMETERS
//  DATA_WIDTH   5  number of result digits converted; result is DATA_WIDTH+1 bits
//  SKIP_DIGITS  0  leading valid digits discarded before conversion (upstream fill)
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  rst           in   1             synchronous, active-low reset
//  start         in   1             pulse: clear and begin a new conversion
//  dig_valid     in   1             dig_in is valid this cycle
//  dig_in        in   2             signed digit: 2'b01=+1, 2'b00=0, 2'b11=-1, 2'b10 illegal
//  result_out    out  DATA_WIDTH+1  two's-complement sum d_i*2^(DATA_WIDTH-i), i=1..DATA_WIDTH
//  result_valid  out  1             one-cycle pulse when result_out is updated
//  busy          out  1             high in SKIP or CONV
//  err           out  1             sticky, illegal digit seen in current conversion
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - state=IDLE; result_out, result_valid, busy and err = 0.
//   - Q=0, QM=all ones, digit counter=0.
//   - Reset has priority over start and digits, including mid-conversion. The partial
//     result is dropped and no result_valid pulse is produced.
//  States: IDLE, SKIP, CONV.
//   - IDLE: dig_valid is ignored. On start: Q=0, QM='1 (-1), cnt=0, err=0.
//     Goes to SKIP if SKIP_DIGITS>0, otherwise to CONV.
//   - SKIP: each valid digit increments cnt. On the SKIP_DIGITS-th valid digit: cnt=0,
//     go to CONV. Digit values are not checked.
//   - CONV: each valid digit updates Q/QM and cnt. On the DATA_WIDTH-th digit, go to IDLE.
//  start in SKIP/CONV: aborts the current op and re-initialises as from IDLE, in the
//   same cycle. No result_valid. A digit in that same cycle is ignored.
//  dig_valid=0: holds all state. Gaps of any length are legal.
//  On-the-fly update (registers DATA_WIDTH+1 bits, wrap-free by construction):
//   - d=+1: Q<={Q,1},  QM<={Q,0}
//   - d= 0: Q<={Q,0},  QM<={QM,1}
//   - d=-1: Q<={QM,1}, QM<={QM,0}
//   - Shifts drop the MSB. The invariant QM==Q-1 holds after every step.
//  Illegal 2'b10 in CONV: treated as d=0 and sets err. err holds until the next start
//   or reset.
//  Completion:
//   - The cycle after the last CONV digit is accepted, result_out=final Q and
//     result_valid=1 for exactly 1 cycle.
//   - Latency is 1 clk after the last digit.
//   - result_out holds until the next completion or reset. start does not clear it.
//  Range: -(2^DATA_WIDTH-1) .. +(2^DATA_WIDTH-1). Overflow is impossible.
//  busy: 1 from the cycle after start until the cycle result_valid rises (both inclusive
//   of the CONV final-digit cycle).
//   - busy=0 in the cycle result_valid=1.
//   - start in the result_valid cycle is legal and begins a new op.
// TESTING
//  1 N=5,S=0: start, digits +1,0,-1,+1,0 back-to-back -> result_out=6'b001110 (14),
//    result_valid 1 clk after 5th digit, err=0
//  2 digits -1,-1,-1,-1,-1 -> 6'b100001 (-31); +1 x5 -> 6'b011111 (31);
//    -1,+1,+1,+1,+1 -> 6'b111111 (-1)
//  3 digits of test 1 with random 0-3 cycle dig_valid gaps -> same 14. Digits sent
//    while IDLE before start have no effect.
//  4 SKIP_DIGITS=2: digits 10,11 (discarded) then +1,0,-1,+1,0 -> 14, err=0
//  5 start after 3 digits, then 5 fresh digits 0,0,0,0,+1 -> single result_valid,
//    result=1. Reset after 3 digits -> all outputs 0, no pulse.
//  6 digit 2'b10 at position 2 of +1,X,0,0,0 -> result 16, err=1 until next start

Source files
------------

// File: rtl/ms_otf_conv_if.sv
// Digit-stream / result bundle between the MSDF digit source and the on-the-fly converter.
// The master drives digits and start; the slave returns the converted word and status.
interface ms_otf_conv_if #(
    parameter int DATA_WIDTH = 5
);
    logic                         start;
    logic                         dig_valid;
    logic        [1:0]            dig_in;
    logic signed [DATA_WIDTH:0]   result_out;
    logic                         result_valid;
    logic                         busy;
    logic                         err;

    modport master (
        output start,
        output dig_valid,
        output dig_in,
        input  result_out,
        input  result_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        input  dig_valid,
        input  dig_in,
        output result_out,
        output result_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/ms_otf_conv.sv
// On-the-fly conversion of an MSDF radix-2 signed-digit stream into a two's-complement word.
// Q holds the converted prefix and QM holds Q-1, so a -1 digit never needs a borrow chain.
module ms_otf_conv #(
    parameter int DATA_WIDTH  = 5,
    parameter int SKIP_DIGITS = 0
) (
    input  logic          clk,
    input  logic          rst,
    ms_otf_conv_if.slave  bus
);
    localparam int W       = DATA_WIDTH + 1;
    localparam int CNT_MAX = (DATA_WIDTH > SKIP_DIGITS) ? DATA_WIDTH : SKIP_DIGITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_DIGITS > 0) ? SKIP_DIGITS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        CONV = 2'd2
    } state_t;

    state_t                  state_p0, state_nxt;
    logic signed [W-1:0]     q_p0, q_nxt;
    logic signed [W-1:0]     qm_p0, qm_nxt;
    logic        [CNT_W-1:0] cnt_p0, cnt_nxt;
    logic                    err_p0, err_nxt;
    logic signed [W-1:0]     result_p1, result_nxt;
    logic                    vld_p1, vld_nxt;

    // Digit code 2'b10 is illegal and falls into the default arm, i.e. behaves as 0.
    function automatic logic signed [W-1:0] otf_q(input logic signed [W-1:0] q,
                                                  input logic signed [W-1:0] qm,
                                                  input logic [1:0]          d);
        case (d)
            2'b01:   return $signed({q[W-2:0], 1'b1});
            2'b11:   return $signed({qm[W-2:0], 1'b1});
            default: return $signed({q[W-2:0], 1'b0});
        endcase
    endfunction

    function automatic logic signed [W-1:0] otf_qm(input logic signed [W-1:0] q,
                                                   input logic signed [W-1:0] qm,
                                                   input logic [1:0]          d);
        case (d)
            2'b01:   return $signed({q[W-2:0], 1'b0});
            2'b11:   return $signed({qm[W-2:0], 1'b0});
            default: return $signed({qm[W-2:0], 1'b1});
        endcase
    endfunction

    always_comb begin
        state_nxt  = state_p0;
        q_nxt      = q_p0;
        qm_nxt     = qm_p0;
        cnt_nxt    = cnt_p0;
        err_nxt    = err_p0;
        result_nxt = result_p1;
        vld_nxt    = 1'b0;

        if (bus.start) begin
            // Restart wins over any digit presented in the same cycle.
            q_nxt     = '0;
            qm_nxt    = '1;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = (SKIP_DIGITS > 0) ? SKIP : CONV;
        end else begin
            case (state_p0)
                SKIP: begin
                    if (bus.dig_valid) begin
                        if (cnt_p0 == SKIP_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = CONV;
                        end else begin
                            cnt_nxt = cnt_p0 + CNT_W'(1);
                        end
                    end
                end
                CONV: begin
                    if (bus.dig_valid) begin
                        q_nxt  = otf_q(q_p0, qm_p0, bus.dig_in);
                        qm_nxt = otf_qm(q_p0, qm_p0, bus.dig_in);
                        if (bus.dig_in == 2'b10) begin
                            err_nxt = 1'b1;
                        end
                        if (cnt_p0 == CONV_LAST) begin
                            cnt_nxt    = '0;
                            state_nxt  = IDLE;
                            result_nxt = q_nxt;
                            vld_nxt    = 1'b1;
                        end else begin
                            cnt_nxt = cnt_p0 + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stage p0 -> p1: conversion state and published result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p0  <= IDLE;
            q_p0      <= '0;
            qm_p0     <= '1;
            cnt_p0    <= '0;
            err_p0    <= 1'b0;
            result_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            state_p0  <= state_nxt;
            q_p0      <= q_nxt;
            qm_p0     <= qm_nxt;
            cnt_p0    <= cnt_nxt;
            err_p0    <= err_nxt;
            result_p1 <= result_nxt;
            vld_p1    <= vld_nxt;
        end
    end

    assign bus.result_out   = result_p1;
    assign bus.result_valid = vld_p1;
    assign bus.busy         = (state_p0 != IDLE);
    assign bus.err          = err_p0;
endmodule

// File: tb/tb_ms_otf_conv.sv
// Bench for ms_otf_conv: directed cases plus randomized digit streams against an arithmetic model,
// on one converter without digit skipping and one that discards two leading digits.
module tb_ms_otf_conv;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ms_otf_conv_if #(.DATA_WIDTH(N)) b0 ();
    ms_otf_conv_if #(.DATA_WIDTH(N)) b1 ();

    ms_otf_conv #(.DATA_WIDTH(N), .SKIP_DIGITS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    ms_otf_conv #(.DATA_WIDTH(N), .SKIP_DIGITS(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Digit values: -1, 0, +1, and 2 stands for the illegal code.
    function automatic logic [1:0] enc(input int d);
        case (d)
            1:       return 2'b01;
            -1:      return 2'b11;
            2:       return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int ref_val(input int ds[$], input int from);
        int v = 0;
        for (int i = from; i < ds.size(); i++) v = v * 2 + ((ds[i] == 2) ? 0 : ds[i]);
        return v;
    endfunction

    function automatic int ref_err(input int ds[$], input int from);
        for (int i = from; i < ds.size(); i++) if (ds[i] == 2) return 1;
        return 0;
    endfunction

    task automatic drive(input int sel, input logic st, input logic v, input logic [1:0] d);
        if (sel == 0) begin
            b0.start = st; b0.dig_valid = v; b0.dig_in = d;
        end else begin
            b1.start = st; b1.dig_valid = v; b1.dig_in = d;
        end
    endtask

    task automatic outs(input int sel, output logic rv, output logic signed [63:0] res,
                        output logic bz, output logic er);
        if (sel == 0) begin
            rv = b0.result_valid; res = $signed(b0.result_out); bz = b0.busy; er = b0.err;
        end else begin
            rv = b1.result_valid; res = $signed(b1.result_out); bz = b1.busy; er = b1.err;
        end
    endtask

    task automatic do_start(input int sel, input string tag);
        logic rv, bz, er;
        logic signed [63:0] res;
        drive(sel, 1'b1, 1'b0, 2'b00);
        tick();
        drive(sel, 1'b0, 1'b0, 2'b00);
        outs(sel, rv, res, bz, er);
        chk({tag, "_start_busy"}, bz, 1);
        chk({tag, "_start_err"}, er, 0);
    endtask

    task automatic send_partial(input int sel, input int ds[$], input string tag);
        logic rv, bz, er;
        logic signed [63:0] res;
        foreach (ds[i]) begin
            drive(sel, 1'b0, 1'b1, enc(ds[i]));
            tick();
            outs(sel, rv, res, bz, er);
            chk($sformatf("%s_part%0d_rv", tag, i), rv, 0);
            chk($sformatf("%s_part%0d_busy", tag, i), bz, 1);
        end
        drive(sel, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic run_conv(input int sel, input int ds[$], input int maxgap,
                            input int expv, input int experr, input string tag);
        logic rv, bz, er;
        logic signed [63:0] res;
        for (int i = 0; i < ds.size(); i++) begin
            int gap;
            gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (gap) begin
                drive(sel, 1'b0, 1'b0, 2'b00);
                tick();
            end
            drive(sel, 1'b0, 1'b1, enc(ds[i]));
            tick();
            outs(sel, rv, res, bz, er);
            if (i == ds.size() - 1) begin
                chk({tag, "_rv"}, rv, 1);
                chk({tag, "_result"}, res, expv);
                chk({tag, "_err"}, er, experr);
                chk({tag, "_busy_done"}, bz, 0);
            end else begin
                chk($sformatf("%s_d%0d_rv", tag, i), rv, 0);
                chk($sformatf("%s_d%0d_busy", tag, i), bz, 1);
            end
        end
        drive(sel, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic tail(input int sel, input int expv, input string tag);
        logic rv, bz, er;
        logic signed [63:0] res;
        tick();
        outs(sel, rv, res, bz, er);
        chk({tag, "_pulse_end"}, rv, 0);
        chk({tag, "_hold"}, res, expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic rv, bz, er;
        logic signed [63:0] res;
        int ds[$];
        drive(0, 1'b0, 1'b0, 2'b00);
        drive(1, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            outs(s, rv, res, bz, er);
            chk($sformatf("reset%0d_rv", s), rv, 0);
            chk($sformatf("reset%0d_result", s), res, 0);
            chk($sformatf("reset%0d_busy", s), bz, 0);
            chk($sformatf("reset%0d_err", s), er, 0);
        end
        rst = 1'b1;
        tick();

        do_start(0, "t1");
        run_conv(0, '{1, 0, -1, 1, 0}, 0, 14, 0, "t1");
        tail(0, 14, "t1");

        do_start(0, "t2a");
        run_conv(0, '{-1, -1, -1, -1, -1}, 0, -31, 0, "t2a");
        do_start(0, "t2b");
        run_conv(0, '{1, 1, 1, 1, 1}, 0, 31, 0, "t2b");
        do_start(0, "t2c");
        run_conv(0, '{-1, 1, 1, 1, 1}, 0, -1, 0, "t2c");
        tail(0, -1, "t2c");

        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b1, 2'b01);
            tick();
            outs(0, rv, res, bz, er);
            chk($sformatf("t3_idle%0d_rv", i), rv, 0);
            chk($sformatf("t3_idle%0d_busy", i), bz, 0);
            chk($sformatf("t3_idle%0d_hold", i), res, -1);
        end
        drive(0, 1'b0, 1'b0, 2'b00);
        do_start(0, "t3");
        run_conv(0, '{1, 0, -1, 1, 0}, 3, 14, 0, "t3");

        do_start(1, "t4");
        run_conv(1, '{2, -1, 1, 0, -1, 1, 0}, 0, 14, 0, "t4");
        tail(1, 14, "t4");

        do_start(0, "t5");
        send_partial(0, '{1, 1, 1}, "t5");
        drive(0, 1'b1, 1'b1, 2'b01);
        tick();
        drive(0, 1'b0, 1'b0, 2'b00);
        outs(0, rv, res, bz, er);
        chk("t5_restart_rv", rv, 0);
        chk("t5_restart_busy", bz, 1);
        run_conv(0, '{0, 0, 0, 0, 1}, 0, 1, 0, "t5");
        tail(0, 1, "t5");

        do_start(0, "t5r");
        send_partial(0, '{1, -1, 1}, "t5r");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            outs(0, rv, res, bz, er);
            chk($sformatf("t5r_%0d_rv", i), rv, 0);
            chk($sformatf("t5r_%0d_result", i), res, 0);
            chk($sformatf("t5r_%0d_busy", i), bz, 0);
            chk($sformatf("t5r_%0d_err", i), er, 0);
            tick();
        end

        do_start(0, "t6");
        run_conv(0, '{1, 2, 0, 0, 0}, 0, 16, 1, "t6");
        tail(0, 16, "t6");
        outs(0, rv, res, bz, er);
        chk("t6_err_sticky", er, 1);
        do_start(0, "t6clr");

        for (int it = 0; it < 30; it++) begin
            int sel, nskip, r, expv, expe;
            sel = it % 2;
            nskip = (sel == 0) ? 0 : 2;
            ds.delete();
            for (int k = 0; k < N + nskip; k++) begin
                r = $urandom_range(0, 15);
                ds.push_back((r < 5) ? -1 : (r < 10) ? 0 : (r < 15) ? 1 : 2);
            end
            expv = ref_val(ds, nskip);
            expe = ref_err(ds, nskip);
            do_start(sel, $sformatf("rnd%0d", it));
            run_conv(sel, ds, 2, expv, expe, $sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) == 1) tail(sel, expv, $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
